// File: rtl/priority_drain_encoder.sv
// Accepts a request vector, then emits the index of each set bit, highest first, one beat per
// out_ready handshake. Optional out_last port under `PRIORITY_DRAIN_LAST_EN`.
module priority_drain_encoder #(
  parameter int unsigned N = 16,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         hit,
  output logic         out_valid,
  input  logic         out_ready
`ifdef PRIORITY_DRAIN_LAST_EN
  ,
  output logic         out_last
`endif
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   top_onehot;
  logic [W-1:0]   top_idx;
  logic           accept, consume;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDrain);
  assign accept    = in_ready & in_valid;
  assign consume   = out_valid & out_ready;

  // One-hot of the highest set bit, then an AND/OR index encode so unknowns propagate.
  always_comb begin : find_top
    logic seen;
    seen       = 1'b0;
    top_onehot = '0;
    top_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      top_onehot[i] = pend_q[i] & ~seen;
      seen          = seen | pend_q[i];
    end
    for (int i = 0; i < N; i++) begin
      top_idx = top_idx | ({W{top_onehot[i]}} & W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pend_d  = a;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (consume) begin
          pend_d = pend_q & ~top_onehot;
          if (pend_d == '0) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs depend on registered state only; an unknown vector yields unknown outputs.
  always_comb begin
    y   = top_idx;
    hit = |pend_q;
`ifndef SYNTHESIS
    if ($isunknown(pend_q)) begin
      y   = 'x;
      hit = 1'bx;
    end
`endif
  end

`ifdef PRIORITY_DRAIN_LAST_EN
  // Final beat: at most one bit left, which includes the all-zero beat.
  assign out_last = out_valid &
                    ((pend_q & (pend_q - {{(N - 1){1'b0}}, 1'b1})) == '0);
`endif

endmodule

// File: tb/tb_priority_drain_encoder.sv
// Directed, table-driven bench for priority_drain_encoder (N=16) plus a short N=4 sequence.
module tb_priority_drain_encoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, in_ready, out_valid, hit;
  logic [15:0] a;
  logic [3:0]  y;
  logic        reset4, in_valid4, out_ready4, in_ready4, out_valid4, hit4;
  logic [3:0]  a4;
  logic [1:0]  y4;
`ifdef PRIORITY_DRAIN_LAST_EN
  logic        out_last, out_last4;
`endif

  priority_drain_encoder #(.N(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .hit       (hit),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PRIORITY_DRAIN_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  priority_drain_encoder #(.N(4)) dut4 (
    .clk       (clk),
    .reset     (reset4),
    .a         (a4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .y         (y4),
    .hit       (hit4),
    .out_valid (out_valid4),
    .out_ready (out_ready4)
`ifdef PRIORITY_DRAIN_LAST_EN
    ,
    .out_last  (out_last4)
`endif
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] a;
    logic        ordy;
    logic        chk;
    logic        e_ir;
    logic        e_ov;
    logic [3:0]  e_y;
    logic        e_hit;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic iv, input logic [15:0] av, input logic ordy,
                     input logic chk, input logic e_ir, input logic e_ov, input logic [3:0] e_y,
                     input logic e_hit, input logic e_last);
    vec_t v;
    v = '{rst, iv, av, ordy, chk, e_ir, e_ov, e_y, e_hit, e_last};
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs driven this cycle, expected registered outputs this cycle.
    //   rst iv a         ordy chk ir ov y   hit last
    add(1, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 0);
    add(0, 1, 16'h8421, 1, 1, 1, 0, 0,  0, 0);  // reset state, accept 8421
    add(0, 0, 16'h0000, 1, 1, 0, 1, 15, 1, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 10, 1, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 5,  1, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0,  1, 1);
    add(0, 1, 16'h0000, 1, 1, 1, 0, 0,  0, 0);  // accept all-zero
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0,  0, 1);
    add(0, 1, 16'h0003, 0, 1, 1, 0, 0,  0, 0);  // accept 0003
    add(0, 0, 16'h0000, 0, 1, 0, 1, 1,  1, 0);  // stalled
    add(0, 0, 16'h0000, 0, 1, 0, 1, 1,  1, 0);
    add(0, 0, 16'h0000, 0, 1, 0, 1, 1,  1, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 1,  1, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0,  1, 1);
    add(0, 1, 16'h0010, 1, 1, 1, 0, 0,  0, 0);  // accept 0010
    add(0, 1, 16'hFFFF, 1, 1, 0, 1, 4,  1, 1);  // FFFF ignored during drain
    add(0, 1, 16'hFFFF, 0, 1, 1, 0, 0,  0, 0);  // FFFF accepted from idle
    add(0, 0, 16'h0000, 0, 1, 0, 1, 15, 1, 0);
    add(1, 0, 16'h0000, 0, 1, 0, 1, 15, 1, 0);  // reset discards FFFF
    add(0, 1, 16'hF000, 1, 1, 1, 0, 0,  0, 0);  // accept F000
    add(0, 0, 16'h0000, 1, 1, 0, 1, 15, 1, 0);
    add(1, 0, 16'h0000, 1, 1, 0, 1, 14, 1, 0);  // reset beats handshake
    add(0, 0, 16'h0000, 1, 1, 1, 0, 0,  0, 0);
    add(0, 0, 16'h0000, 1, 1, 1, 0, 0,  0, 0);  // no 13/12 beats
    add(1, 1, 16'h0001, 1, 1, 1, 0, 0,  0, 0);  // reset beats acceptance
    add(0, 0, 16'h0000, 1, 1, 1, 0, 0,  0, 0);

    reset = 1'b1; in_valid = 1'b0; a = '0; out_ready = 1'b0;
    reset4 = 1'b1; in_valid4 = 1'b0; a4 = '0; out_ready4 = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      reset     = vecs[k].rst;
      in_valid  = vecs[k].iv;
      a         = vecs[k].a;
      out_ready = vecs[k].ordy;
      #1;
      if (vecs[k].chk) begin
        check($sformatf("row%0d in_ready", k), 32'(in_ready), 32'(vecs[k].e_ir));
        check($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(vecs[k].e_ov));
        check($sformatf("row%0d y", k), 32'(y), 32'(vecs[k].e_y));
        check($sformatf("row%0d hit", k), 32'(hit), 32'(vecs[k].e_hit));
`ifdef PRIORITY_DRAIN_LAST_EN
        check($sformatf("row%0d out_last", k), 32'(out_last), 32'(vecs[k].e_last));
`endif
      end
    end

    // N=4: 0110 drains as y=2 then y=1.
    @(negedge clk);
    reset4 = 1'b0; in_valid4 = 1'b1; a4 = 4'b0110; out_ready4 = 1'b1;
    #1;
    check("n4 in_ready idle", 32'(in_ready4), 32'd1);
    check("n4 out_valid idle", 32'(out_valid4), 32'd0);
    @(negedge clk);
    in_valid4 = 1'b0; a4 = '0;
    #1;
    check("n4 beat0 out_valid", 32'(out_valid4), 32'd1);
    check("n4 beat0 y", 32'(y4), 32'd2);
    check("n4 beat0 hit", 32'(hit4), 32'd1);
`ifdef PRIORITY_DRAIN_LAST_EN
    check("n4 beat0 out_last", 32'(out_last4), 32'd0);
`endif
    @(negedge clk);
    #1;
    check("n4 beat1 out_valid", 32'(out_valid4), 32'd1);
    check("n4 beat1 y", 32'(y4), 32'd1);
    check("n4 beat1 hit", 32'(hit4), 32'd1);
`ifdef PRIORITY_DRAIN_LAST_EN
    check("n4 beat1 out_last", 32'(out_last4), 32'd1);
`endif
    @(negedge clk);
    #1;
    check("n4 done in_ready", 32'(in_ready4), 32'd1);
    check("n4 done out_valid", 32'(out_valid4), 32'd0);
    check("n4 done hit", 32'(hit4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_drain_encoder.md
PRIORITY_DRAIN_ENCODER -- requirements
Module: priority_drain_encoder

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning request vector width (N >= 2).
REQ-002 The block SHALL have derived localparam W, default $clog2(N), meaning index width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port a, input, N bits: request vector; bit i set means request i is active.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a this cycle.
REQ-008 The block SHALL have port y, output, W bits: index of the current highest-priority set bit.
REQ-009 The block SHALL have port hit, output, 1 bit: 1 when y refers to a set bit; 0 for an all-zero vector.
REQ-010 The block SHALL have port out_valid, output, 1 bit: y/hit are valid this cycle.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes y/hit this cycle.

Function
REQ-012 The block SHALL implement two states, IDLE and DRAIN; in_ready = (state == IDLE), and out_valid = (state == DRAIN).
REQ-013 In IDLE, when in_valid is high (in_ready is always high in IDLE), the block SHALL load a into the internal register pend and enter DRAIN on the next edge; out_valid SHALL be high one cycle after acceptance.
REQ-014 In DRAIN, y SHALL be the index of the highest set bit of pend, and hit SHALL be |pend; both SHALL be driven from registers only, with no combinational path from a, in_valid or out_ready.
REQ-015 In DRAIN, on out_valid && out_ready, the block SHALL clear the bit of pend at index y.
REQ-016 If clearing that bit leaves pend zero, the block SHALL return to IDLE on the same edge.
REQ-017 An accepted vector with k set bits (k >= 1) SHALL produce exactly k output beats, in descending index order.
REQ-018 An accepted all-zero vector SHALL produce exactly one beat with y = 0 and hit = 0, then return to IDLE.
REQ-019 While out_valid is high and out_ready is low, y, hit and pend SHALL hold stable.
REQ-020 in_valid asserted during DRAIN SHALL be ignored, and a SHALL NOT be sampled.
REQ-021 The minimum turnaround SHALL be one IDLE cycle between the last output beat and the next acceptance.
REQ-022 In simulation, if a contains X or Z bits when accepted, y and hit SHALL read X during DRAIN (unknown in, unknown out).

Reset
REQ-023 While reset is high at a clock edge, the block SHALL enter IDLE with pend = 0, giving out_valid = 0, in_ready = 1, y = 0 and hit = 0 on the next cycle.
REQ-024 Reset SHALL take priority over acceptance and output handshakes in the same cycle.
REQ-025 Reset asserted mid-DRAIN SHALL discard all remaining pending bits, and no further beats of that vector SHALL be emitted.

Configuration
REQ-026 When macro PRIORITY_DRAIN_LAST_EN is defined, the block SHALL add port out_last, output, 1 bit.
REQ-027 With PRIORITY_DRAIN_LAST_EN defined, out_last SHALL be high on the final beat of each vector (pend has at most one set bit), including the all-zero beat, and SHALL be 0 after reset.
REQ-028 When PRIORITY_DRAIN_LAST_EN is undefined, out_last SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover: N=16, reset, then a=16'h8421 accepted with out_ready=1 -> beats y=15,10,5,0 on four consecutive cycles, hit=1 on each, out_last only on y=0.
REQ-030 The bench SHALL cover: a=16'h0000 accepted -> one beat with y=0, hit=0, out_last=1; in_ready high again the next cycle.
REQ-031 The bench SHALL cover: a=16'h0003 with out_ready low for 3 cycles -> y=1 held stable for 3 cycles, then y=1 and y=0 beats once out_ready rises.
REQ-032 The bench SHALL cover: in_valid held high with a=16'hFFFF during DRAIN of 16'h0010 -> only y=4 is emitted, and 16'hFFFF is accepted only after the return to IDLE.
REQ-033 The bench SHALL cover: reset pulsed after the first beat of 16'hF000 -> out_valid=0 and in_ready=1 the next cycle, with no y=13..12 beats.
REQ-034 The bench SHALL cover: N=4 build with a=4'b0110 -> y=2 then y=1 (2-bit y), matching the legacy 4-2 priority order.
